// File: rtl/seg7_multi_display_if.sv
// Front-panel display bus: load strobe with value/format on one side, conversion
// status and active-low segment outputs on the other.
interface seg7_multi_display_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 4
);
  logic                  load;
  logic [DATA_W-1:0]     value;
  logic [1:0]            mode;
  logic                  blank_lz;
  logic                  blink_en;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [7*DIGITS-1:0]   hex_seg;

  modport master (
    output load, value, mode, blank_lz, blink_en,
    input  busy, done, overflow, hex_seg
  );

  modport slave (
    input  load, value, mode, blank_lz, blink_en,
    output busy, done, overflow, hex_seg
  );
endinterface

// File: rtl/seg7_multi_display.sv
// Registered multi-digit 7-segment driver: hex, unsigned or signed decimal via a
// sequential double-dabble engine, with zero blanking, overflow and blink gating.
module seg7_multi_display #(
  parameter int DATA_W    = 8,
  parameter int DIGITS    = 4,
  parameter int BLINK_DIV = 25000000
) (
  input logic                 clk,
  input logic                 rst_n,
  seg7_multi_display_if.slave bus
);
  localparam int BCD_N = (DATA_W * 301) / 1000 + 1;
  localparam int NIB   = (DATA_W + 3) / 4;
  localparam int SH_W  = 4 * BCD_N + DATA_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONVERT, FORMAT} state_t;

  state_t                    state, state_nx;
  logic [CNT_W-1:0]          bit_cnt;
  logic [SH_W-1:0]           dab_sh;
  logic [1:0]                mode_q;
  logic                      blz_q, neg_q;
  logic signed [DATA_W-1:0]  value_s;
  logic [DATA_W-1:0]         mag;
  logic [7*DIGITS-1:0]       seg_q, seg_nx;
  logic                      ovf_q, ovf_nx, done_q;
  logic [BLK_W-1:0]          blk_cnt;
  logic                      phase;
  logic [3:0]                dig [DIGITS];
  logic [6:0]                glyph;
  logic                      dec;
  int                        msd, req;

  function automatic logic [6:0] hex_glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] nib_at(input logic [SH_W-1:0] sh, input int pos);
    return 4'(sh >> pos);
  endfunction

  // BCD field sits above the binary field; adjust then shift the whole register.
  function automatic logic [SH_W-1:0] dabble_step(input logic [SH_W-1:0] sh);
    logic [SH_W-1:0] t;
    t = sh;
    for (int i = 0; i < BCD_N; i++)
      if (t[DATA_W+4*i +: 4] >= 4'd5) t[DATA_W+4*i +: 4] = t[DATA_W+4*i +: 4] + 4'd3;
    return t << 1;
  endfunction

  assign value_s = bus.value;

  always_comb begin
    mag = bus.value;
    if (bus.mode == 2'b10 && bus.value[DATA_W-1]) mag = DATA_W'(-value_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.load) state_nx = (bus.mode == 2'b01 || bus.mode == 2'b10) ? CONVERT : FORMAT;
      CONVERT: if (bit_cnt == CNT_W'(DATA_W - 1)) state_nx = FORMAT;
      FORMAT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      seg_q   <= '1;
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      done_q <= (state == FORMAT);
      if (state == IDLE)         bit_cnt <= '0;
      else if (state == CONVERT) bit_cnt <= bit_cnt + CNT_W'(1);
      if (state == FORMAT) begin
        seg_q <= seg_nx;
        ovf_q <= ovf_nx;
      end
      if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.load) begin
      dab_sh <= {{(4*BCD_N){1'b0}}, mag};
      mode_q <= bus.mode;
      blz_q  <= bus.blank_lz;
      neg_q  <= (bus.mode == 2'b10) && bus.value[DATA_W-1];
    end else if (state == CONVERT) begin
      dab_sh <= dabble_step(dab_sh);
    end
  end

  // Hex reads the binary field directly; decimal reads the converted BCD field.
  always_comb begin
    dec    = (mode_q == 2'b01) || (mode_q == 2'b10);
    ovf_nx = 1'b0;
    msd    = 0;
    req    = 1;
    glyph  = SEG_BLANK;
    seg_nx = '1;
    for (int i = 0; i < DIGITS; i++) begin
      dig[i] = dec ? nib_at(dab_sh, DATA_W + 4 * i) : nib_at(dab_sh, 4 * i);
      if (dig[i] != 4'd0) msd = i;
    end
    if (dec) begin
      for (int i = 0; i < BCD_N; i++)
        if (nib_at(dab_sh, DATA_W + 4 * i) != 4'd0) req = i + 1;
      if (req + int'(neg_q) > DIGITS) ovf_nx = 1'b1;
    end else if (mode_q == 2'b00) begin
      for (int i = DIGITS; i < NIB; i++)
        if (nib_at(dab_sh, 4 * i) != 4'd0) ovf_nx = 1'b1;
    end
    for (int i = 0; i < DIGITS; i++) begin
      glyph = hex_glyph(dig[i]);
      if (mode_q == 2'b11)     glyph = SEG_BLANK;
      else if (ovf_nx && dec)  glyph = SEG_MINUS;
      else if (i > msd) begin
        if (neg_q && i == (blz_q ? msd + 1 : DIGITS - 1)) glyph = SEG_MINUS;
        else if (blz_q)                                    glyph = SEG_BLANK;
      end
      seg_nx[7*i +: 7] = glyph;
    end
  end

  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.hex_seg  = (bus.blink_en && phase) ? '1 : seg_q;
endmodule

// File: tb/tb_seg7_multi_display.sv
// Directed bench for seg7_multi_display: expected glyphs are queued at load time
// and checked when done pulses; a second instance covers the 3-digit overflow case.
module tb_seg7_multi_display;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pc;
  logic [27:0] exp_seg_q[$];
  logic        exp_ovf_q[$];

  always #5 clk = ~clk;

  seg7_multi_display_if #(.DATA_W(DW), .DIGITS(4)) bus ();
  seg7_multi_display_if #(.DATA_W(DW), .DIGITS(3)) bus3 ();

  seg7_multi_display #(.DATA_W(DW), .DIGITS(4), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  seg7_multi_display #(.DATA_W(DW), .DIGITS(3), .BLINK_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  // Posedges since reset release; the blink phase follows from this count.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= 0;
    else        pc <= pc + 1;

  function automatic logic [27:0] seg4(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] m, input logic [7:0] v, input logic blz,
                       input logic [27:0] es, input logic eo);
    bus.load = 1'b1; bus.value = v; bus.mode = m; bus.blank_lz = blz;
    exp_seg_q.push_back(es);
    exp_ovf_q.push_back(eo);
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic collect(input string tag, input int lat, input int start);
    int n;
    logic [27:0] es;
    logic eo;
    n = start;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " sb depth"}, 32'(exp_seg_q.size()), 32'd1);
    if (exp_seg_q.size() > 0) begin
      es = exp_seg_q.pop_front();
      eo = exp_ovf_q.pop_front();
      chk({tag, " hex_seg"}, {4'h0, bus.hex_seg}, {4'h0, es});
      chk({tag, " overflow"}, {31'h0, bus.overflow}, {31'h0, eo});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int n;
    logic [27:0] g3c;
    g3c = seg4(7'h40, 7'h40, 7'h30, 7'h46);
    bus.load = 0;  bus.value = 0;  bus.mode = 0;  bus.blank_lz = 0;  bus.blink_en = 0;
    bus3.load = 0; bus3.value = 0; bus3.mode = 0; bus3.blank_lz = 0; bus3.blink_en = 0;
    repeat (2) @(negedge clk);
    chk("reset hex_seg", {4'h0, bus.hex_seg}, {4'h0, 28'hFFFFFFF});
    chk("reset busy", {31'h0, bus.busy}, 32'd0);
    chk("reset done", {31'h0, bus.done}, 32'd0);
    chk("reset overflow", {31'h0, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(2'b00, 8'h3C, 1'b0, g3c, 1'b0);
    collect("hex 3C", 2, 1);
    @(negedge clk);
    chk("done pulse width", {31'h0, bus.done}, 32'd0);

    issue(2'b01, 8'd255, 1'b1, seg4(7'h7F, 7'h24, 7'h12, 7'h12), 1'b0);
    for (int k = 1; k <= 9; k++) begin
      chk("busy during dec", {31'h0, bus.busy}, 32'd1);
      if (k < 9) @(negedge clk);
    end
    collect("udec 255", 10, 9);
    chk("busy after done", {31'h0, bus.busy}, 32'd0);

    issue(2'b10, 8'h80, 1'b1, seg4(7'h3F, 7'h79, 7'h24, 7'h00), 1'b0);
    collect("sdec -128", 10, 1);
    issue(2'b10, 8'hFB, 1'b0, seg4(7'h3F, 7'h40, 7'h40, 7'h12), 1'b0);
    collect("sdec -5 lz0", 10, 1);
    issue(2'b10, 8'hFB, 1'b1, seg4(7'h7F, 7'h7F, 7'h3F, 7'h12), 1'b0);
    collect("sdec -5 lz1", 10, 1);
    issue(2'b10, 8'h7F, 1'b1, seg4(7'h7F, 7'h79, 7'h24, 7'h78), 1'b0);
    collect("sdec 127", 10, 1);
    issue(2'b00, 8'hAB, 1'b1, seg4(7'h7F, 7'h7F, 7'h08, 7'h03), 1'b0);
    collect("hex AB lz1", 2, 1);
    issue(2'b11, 8'h55, 1'b0, seg4(7'h7F, 7'h7F, 7'h7F, 7'h7F), 1'b0);
    collect("blank mode", 2, 1);

    issue(2'b01, 8'd0, 1'b1, seg4(7'h7F, 7'h7F, 7'h7F, 7'h40), 1'b0);
    @(negedge clk);
    bus.load = 1'b1; bus.value = 8'd99; bus.mode = 2'b01;
    @(negedge clk);
    bus.load = 1'b0;
    collect("udec 0", 10, 3);
    issue(2'b00, 8'h3C, 1'b0, g3c, 1'b0);
    collect("load in done cycle", 2, 1);
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    chk("no extra done", 32'(nd), 32'd0);

    issue(2'b01, 8'd200, 1'b0, seg4(7'h40, 7'h24, 7'h40, 7'h40), 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset hex_seg", {4'h0, bus.hex_seg}, {4'h0, 28'hFFFFFFF});
    chk("midreset busy", {31'h0, bus.busy}, 32'd0);
    exp_seg_q.delete();
    exp_ovf_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    chk("no done after abort", 32'(nd), 32'd0);
    issue(2'b01, 8'd200, 1'b0, seg4(7'h40, 7'h24, 7'h40, 7'h40), 1'b0);
    collect("udec 200 after reset", 10, 1);

    bus3.load = 1'b1; bus3.value = 8'h80; bus3.mode = 2'b10; bus3.blank_lz = 1'b1;
    @(negedge clk);
    bus3.load = 1'b0;
    n = 1;
    while (bus3.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("d3 -128 latency", 32'(n), 32'd10);
    chk("d3 -128 hex_seg", {11'h0, bus3.hex_seg}, {11'h0, 7'h3F, 7'h3F, 7'h3F});
    chk("d3 -128 overflow", {31'h0, bus3.overflow}, 32'd1);
    bus3.load = 1'b1; bus3.value = 8'd200; bus3.mode = 2'b01; bus3.blank_lz = 1'b0;
    @(negedge clk);
    bus3.load = 1'b0;
    chk("d3 overflow held", {31'h0, bus3.overflow}, 32'd1);
    n = 1;
    while (bus3.done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("d3 200 hex_seg", {11'h0, bus3.hex_seg}, {11'h0, 7'h24, 7'h40, 7'h40});
    chk("d3 200 overflow", {31'h0, bus3.overflow}, 32'd0);

    @(negedge clk);
    issue(2'b00, 8'h3C, 1'b0, g3c, 1'b0);
    collect("hex 3C pre-blink", 2, 1);
    bus.blink_en = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("blink", {4'h0, bus.hex_seg}, ((pc / 4) % 2 == 1) ? {4'h0, 28'hFFFFFFF} : {4'h0, g3c});
    end
    bus.blink_en = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("blink off", {4'h0, bus.hex_seg}, {4'h0, g3c});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_multi_display.md
Name: seg7_multi_display

Overview:
Parametrised, registered multi-digit 7-segment driver for the RPN ALU front panel, replacing per-nibble combinational decoding. It accepts a DATA_W-bit result with a load strobe and renders it on DIGITS displays as hex, unsigned decimal or signed decimal. Decimal values are converted by a sequential double-dabble engine. Outputs include leading-zero blanking, minus sign, overflow indication and blink.

Parameters:
DATA_W, 8, width of value (>=4)
DIGITS, 4, number of 7-segment digits driven (>=1)
BLINK_DIV, 25000000, clk cycles per blink half-period (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
load  in  1  capture value/mode/blank_lz when idle
value  in  DATA_W  number to display
mode  in  2  00 hex, 01 unsigned decimal, 10 signed (two's complement) decimal, 11 blank
blank_lz  in  1  1 = blank leading zeros
blink_en  in  1  1 = flash whole display at BLINK_DIV rate
busy  out  1  conversion in progress; load ignored
done  out  1  one-cycle pulse, new glyphs visible this cycle
overflow  out  1  last accepted value did not fit DIGITS
hex_seg  out  7*DIGITS  digit i at [7i+6:7i], digit 0 rightmost; bit0=a .. bit6=g; active-low (1 = segment off)

Behaviour:
- Reset (async, rst_n=0): state IDLE, hex_seg all ones, busy=0, done=0, overflow=0, blink counter=0, phase=0. Reset mid-conversion aborts it; no done follows.
- FSM: IDLE -> (load) CONVERT (mode 01/10) or FORMAT (mode 00/11); CONVERT -> FORMAT after DATA_W shift cycles; FORMAT -> IDLE.
- load is sampled only in IDLE. busy=1 in CONVERT and FORMAT. done is registered and asserts on the edge leaving FORMAT, together with the hex_seg update. load in the done cycle is accepted.
- Latency, from the edge that samples load to done/hex_seg valid: hex/blank 2 edges; decimal DATA_W+2 edges.
- Signed mode: if value[DATA_W-1]=1, magnitude = two's-complement negation of value; -2^(DATA_W-1) is handled correctly as an unsigned DATA_W-bit magnitude.
- Double dabble: BCD_N = (DATA_W*301)/1000+1 BCD digits. Each CONVERT cycle adds 3 to every BCD nibble >=5, then shifts left one bit.
- Hex glyphs: 0-9, A, b, C, d, E, F, with standard segment patterns (0=0x40, 1=0x79, 2=0x24, 3=0x30, 5=0x12, 8=0x00, C=0x46). Minus = 0x3F. Blank = 0x7F.
- Leading-zero blanking: zeros above the most significant non-zero digit are blank. Digit 0 is always shown.
- Minus placement: blank_lz=1 puts the minus in the digit left of the most significant digit. blank_lz=0 puts it in digit DIGITS-1, with zeros in between.
- Overflow, decimal: required digits (+1 if negative) > DIGITS -> all digits show minus, overflow=1.
- Overflow, hex: non-zero nibbles above DIGITS -> low DIGITS nibbles shown, overflow=1.
- overflow updates only with done. Mode 11 gives overflow=0 and all digits blank.
- Blink: a free-running counter toggles phase every BLINK_DIV cycles. hex_seg = all ones while blink_en=1 and phase=1; otherwise the stored glyphs. The gating is combinational from registers, and blink_en takes effect without a load.
- A new load never blanks the display during conversion; the old glyphs are held until done.

Test Plan:
- DATA_W=8, DIGITS=4, mode 00, value 0x3C, blank_lz=0 -> done 2 edges after load; hex_seg digits3..0 = 0x40, 0x40, 0x30, 0x46; overflow=0.
- mode 01, value 255, blank_lz=1 -> done at edge 10; digits = 0x7F, 0x24, 0x12, 0x12; busy high for edges 1-9.
- mode 10, value 0x80, blank_lz=1 -> "-128" = 0x3F, 0x79, 0x24, 0x00; same value with DIGITS=3 -> 0x3F, 0x3F, 0x3F, overflow=1.
- mode 01, value 0, blank_lz=1 -> 0x7F, 0x7F, 0x7F, 0x40. A second load pulsed while busy is ignored (exactly one done). A load in the done cycle is accepted.
- rst_n low at edge 5 of a decimal conversion -> hex_seg all ones, busy=0, no done. Next load behaves normally.
- BLINK_DIV=4, blink_en=1 after displaying 0x3C -> hex_seg alternates glyphs for 4 cycles, then all ones for 4 cycles. blink_en=0 -> glyphs shown steadily.
